// File: rtl/alu_pkg.sv
// Shared opcode map and controller state encoding for the sequential ALU.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [OP_W-1:0] ALU_CMP  = 4'd1;
  localparam logic [OP_W-1:0] ALU_NAND = 4'd2;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'd3;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'd4;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'd5;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'd6;
  localparam logic [OP_W-1:0] ALU_MUL  = 4'd7;
  localparam logic [OP_W-1:0] ALU_PASS = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_step.sv
// One combinational shift-add step: adds the multiplicand into the high
// partial product when the current multiplier bit is set.
module alu_mul_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] partial,
  input  logic [WIDTH-1:0] mcand,
  input  logic             mbit,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, partial} + (mbit ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake; single-cycle ops complete on
// acceptance, MUL runs WIDTH shift-add steps before presenting its result.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             op_err
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH:0] SHIFT_LIM = (WIDTH+1)'(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] result_reg;
  logic             flag_z_reg, flag_n_reg, flag_c_reg, flag_v_reg;
  logic             op_err_reg, out_valid_reg;

  // Single-cycle datapath
  logic [WIDTH:0]   add_full, sub_full;
  logic             shift_oob;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_err;

  assign add_full  = {1'b0, a} + {1'b0, b};
  assign sub_full  = {1'b0, a} - {1'b0, b};
  assign shift_oob = ({1'b0, b} >= SHIFT_LIM);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op)
      ALU_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_CMP, ALU_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_NAND: alu_res = ~(a & b);
      ALU_SLT:  alu_res = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      ALU_SRL:  alu_res = shift_oob ? '0 : (a >> b);
      ALU_SLL:  alu_res = shift_oob ? '0 : (a << b);
      ALU_PASS: alu_res = imm;
      ALU_MUL:  alu_res = '0;
      default:  alu_err = 1'b1;
    endcase
  end

  // Multiply step: {hi, lo} shifts right as the multiplier bits in lo are consumed
  logic [WIDTH-1:0] step_sum;
  logic             step_carry;
  logic [WIDTH-1:0] hi_next, lo_next;

  alu_mul_step #(.WIDTH(WIDTH)) u_step (
    .partial (hi_reg),
    .mcand   (mcand_reg),
    .mbit    (lo_reg[0]),
    .sum     (step_sum),
    .carry   (step_carry)
  );

  assign hi_next = {step_carry, step_sum[WIDTH-1:1]};
  assign lo_next = {step_sum[0], lo_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      mcand_reg     <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      result_reg    <= '0;
      flag_z_reg    <= 1'b0;
      flag_n_reg    <= 1'b0;
      flag_c_reg    <= 1'b0;
      flag_v_reg    <= 1'b0;
      op_err_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            if (op == ALU_MUL) begin
              mcand_reg <= a;
              lo_reg    <= b;
              hi_reg    <= '0;
              cnt_reg   <= '0;
              state_reg <= ST_MUL;
            end else begin
              result_reg    <= alu_res;
              flag_z_reg    <= (alu_res == '0);
              flag_n_reg    <= alu_res[WIDTH-1];
              flag_c_reg    <= alu_c;
              flag_v_reg    <= alu_v;
              op_err_reg    <= alu_err;
              out_valid_reg <= 1'b1;
              state_reg     <= ST_HOLD;
            end
          end
        end
        ST_MUL: begin
          hi_reg  <= hi_next;
          lo_reg  <= lo_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_STEP) begin
            result_reg    <= lo_next;
            flag_z_reg    <= (lo_next == '0);
            flag_n_reg    <= lo_next[WIDTH-1];
            flag_c_reg    <= 1'b0;
            flag_v_reg    <= (hi_next != '0);
            op_err_reg    <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign flag_z    = flag_z_reg;
  assign flag_n    = flag_n_reg;
  assign flag_c    = flag_c_reg;
  assign flag_v    = flag_v_reg;
  assign op_err    = op_err_reg;

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the datapath's 8-bit combinational ALU.
- Width is generic and defaults to 8.
- Adds subtract, shift-left, an iterative shift-add multiply, and a full registered flag set (Z, N, C, V).
- Uses a valid/ready handshake on both input and output, so the multi-cycle control unit can stall on multiply.
- Sits between the register-file read stage and the accumulator write-back.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range ≥ 4.
- OP_W, 4: opcode field width; fixed by the shared package.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and opcode presented.
- in_ready  out  1  block can accept an operation.
- op  in  OP_W  operation code.
- a  in  WIDTH  operand A; two's complement when signed.
- b  in  WIDTH  operand B, or shift amount.
- imm  in  WIDTH  value for PASS (syscall read into accumulator).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  registered result.
- flag_z  out  1  result == 0.
- flag_n  out  1  result[WIDTH-1].
- flag_c  out  1  carry out (ADD) or borrow (SUB/CMP).
- flag_v  out  1  signed overflow (ADD/SUB/CMP); unsigned product overflow (MUL).
- op_err  out  1  opcode was unassigned.

Behaviour:

Reset:
- rst_n low at any time, including mid-multiply: state returns to IDLE immediately.
- result, all flags, op_err and out_valid are forced to 0.
- Any in-flight operation is discarded; no partial result is ever presented.

Opcodes:
- 0 ADD: a+b.
- 1 CMP: a−b, used for beq via flag_z.
- 2 NAND.
- 3 SLT: signed compare, result 1 or 0.
- 4 SRL: logical right shift.
- 5 SUB.
- 6 SLL.
- 7 MUL: low WIDTH bits of unsigned a*b.
- 8 PASS: result = imm.
- 9–15: result 0, op_err = 1, other flags computed normally from the zero result.

Shift amount:
- b interpreted unsigned; if b ≥ WIDTH the result is 0.

Flags:
- All four flags are updated on every completed operation.
- flag_c and flag_v are 0 for operations other than those listed on the ports.

State machine (IDLE, MUL, HOLD):
- in_ready = (state == IDLE).
- IDLE with in_valid:
  - Non-MUL op: result and flags registered; next state HOLD with out_valid = 1. Latency is 1 cycle.
  - MUL op: latch a, b; clear the partial product and the WIDTH-bit high accumulator; next state MUL.
- MUL: one shift-add step per cycle, consuming b LSB-first. After exactly WIDTH cycles, go to HOLD.
  - result = low half of the product.
  - flag_v = (high half ≠ 0).
  - MUL latency is WIDTH+1 cycles from acceptance to out_valid.
- HOLD: result, flags and out_valid are held stable while out_ready = 0.
  - On out_ready = 1: next state IDLE, out_valid = 0.
  - No new acceptance in that same cycle; one bubble per operation is required.
- in_valid while busy is ignored; the source must hold it until in_ready.
- All arithmetic is modulo 2^WIDTH. Carry is taken from a (WIDTH+1)-bit sum.
- Signed overflow rules:
  - ADD: operands share a sign and the result sign differs.
  - SUB/CMP: operand signs differ and the result sign differs from a.

Decomposition:
- Shared package alu_pkg holds:
  - OP_W.
  - Opcode localparams (ALU_ADD … ALU_PASS).
  - State encoding (ST_IDLE, ST_MUL, ST_HOLD).
- One sub-module, alu_mul_step: a single combinational shift-add step (partial product, multiplicand, multiplier bit → next partial product and carry). seq_alu instantiates and sequences it.
- Single-cycle ops stay inline in seq_alu.

Test Plan (WIDTH=8):
- ADD a=0x7F, b=0x01 → result 0x80; flags N=1, V=1, C=0, Z=0; out_valid one cycle after acceptance.
- ADD a=0xFF, b=0x01 → result 0x00; flags Z=1, C=1, V=0. Then CMP a=0x05, b=0x05 → Z=1, C=0.
- MUL a=0x0F, b=0x11 → result 0xFF, V=0, out_valid 9 cycles after acceptance.
  - Then MUL a=0x10, b=0x10 → result 0x00, Z=1, V=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after SLT a=0x80, b=0x01: result stays 0x01 and out_valid stays 1 throughout.
  - in_ready=0 throughout; in_valid pulses are ignored.
  - out_ready=1 → IDLE.
- Shifts and errors:
  - SRL a=0xF0, b=3 → 0x1E.
  - SLL a=0x81, b=1 → 0x02.
  - SLL with b=8 → 0x00, Z=1.
  - op=12 → result 0x00, op_err=1.
- Assert rst_n low 4 cycles into a MUL:
  - All outputs are 0 asynchronously; in_ready=1 after release.
  - A subsequent ADD a=0x02, b=0x03 → 0x05 with no residue from the aborted MUL.
